// File: rtl/msg_defs_pkg.sv
// Shared message-path definitions: header layout constants, the effective-length rule,
// and the FSM state type used by both the transmit header mux and the receiver.
package msg_defs_pkg;

  localparam logic [7:0] SYNC_BYTE_LO      = 8'h34;
  localparam logic [7:0] SYNC_BYTE_HI      = 8'h12;
  localparam int         HEADER_BYTE_COUNT = 8;

  localparam logic [2:0] HDR_IDX_SYNC_LO  = 3'd0;
  localparam logic [2:0] HDR_IDX_SYNC_HI  = 3'd1;
  localparam logic [2:0] HDR_IDX_COUNT_LO = 3'd2;
  localparam logic [2:0] HDR_IDX_COUNT_HI = 3'd3;
  localparam logic [2:0] HDR_IDX_ID_LO    = 3'd4;
  localparam logic [2:0] HDR_IDX_ID_HI    = 3'd5;
  localparam logic [2:0] HDR_IDX_SEQ_LO   = 3'd6;
  localparam logic [2:0] HDR_IDX_SEQ_HI   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_HEADER_WAIT = 3'd1,
    ST_HEADER_HOLD = 3'd2,
    ST_DATA_READ   = 3'd3,
    ST_DATA_WAIT   = 3'd4,
    ST_DATA_HOLD   = 3'd5,
    ST_MSG_DONE    = 3'd6
  } msg_state_e;

  // A message is never shorter than its header, whatever the byte-count field says.
  function automatic logic [15:0] msg_eff_len(input logic [15:0] byte_count);
    return (byte_count < 16'(HEADER_BYTE_COUNT)) ? 16'(HEADER_BYTE_COUNT) : byte_count;
  endfunction

endpackage

// File: rtl/msg_header_rom.sv
// Combinational 8:1 select of the latched header fields, little-endian, by byte index.
module msg_header_rom
  import msg_defs_pkg::*;
(
  input  logic [2:0]  byte_idx,
  input  logic [15:0] byte_count,
  input  logic [15:0] message_id,
  input  logic [15:0] seq_num,
  output logic [7:0]  hdr_byte
);

  always_comb begin
    hdr_byte = SYNC_BYTE_LO;
    case (byte_idx)
      HDR_IDX_SYNC_HI:  hdr_byte = SYNC_BYTE_HI;
      HDR_IDX_COUNT_LO: hdr_byte = byte_count[7:0];
      HDR_IDX_COUNT_HI: hdr_byte = byte_count[15:8];
      HDR_IDX_ID_LO:    hdr_byte = message_id[7:0];
      HDR_IDX_ID_HI:    hdr_byte = message_id[15:8];
      HDR_IDX_SEQ_LO:   hdr_byte = seq_num[7:0];
      HDR_IDX_SEQ_HI:   hdr_byte = seq_num[15:8];
      default:          hdr_byte = SYNC_BYTE_LO;
    endcase
  end

endmodule

// File: rtl/msg_header_mux.sv
// Sends an 8-byte header then payload RAM bytes to the serializer; first LoadByte 1 cycle after Start,
// SerialReady low stalls in the wait states. Define MSG_AUTO_SEQ_EN to use an internal sequence counter.
module msg_header_mux
  import msg_defs_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       Clock,
  input  logic                       Clear,
  input  logic                       Start,
  input  logic [15:0]                MessageID,
  input  logic [15:0]                SequenceNumber,
  input  logic [15:0]                ByteCount,
  output logic                       Busy,
  output logic                       MessageSent,
  output logic [7:0]                 MessageByte,
  output logic                       LoadByte,
  input  logic                       SerialReady,
  output logic [DATA_ADDR_WIDTH-1:0] DataAddr,
  input  logic [7:0]                 DataByte
);

  localparam logic [15:0] HDR_LEN = 16'(HEADER_BYTE_COUNT);

  msg_state_e                 state_q, state_d;
  logic [15:0]                msg_id_q, msg_id_d;
  logic [15:0]                byte_count_q, byte_count_d;
  logic [15:0]                seq_q, seq_d;
  logic [15:0]                sent_count_q, sent_count_d;
  logic                       busy_q, busy_d;
  logic                       msg_sent_q, msg_sent_d;
  logic                       load_q, load_d;
  logic [7:0]                 msg_byte_q, msg_byte_d;
  logic [DATA_ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
  logic [7:0]                 hdr_byte;
  logic [15:0]                eff_len;

`ifdef MSG_AUTO_SEQ_EN
  logic unused_seq_in;
  assign unused_seq_in = ^SequenceNumber;
`endif

  assign eff_len = msg_eff_len(byte_count_q);

  msg_header_rom u_hdr_rom (
    .byte_idx   (sent_count_q[2:0]),
    .byte_count (byte_count_q),
    .message_id (msg_id_q),
    .seq_num    (seq_q),
    .hdr_byte   (hdr_byte)
  );

  always_comb begin
    state_d      = state_q;
    msg_id_d     = msg_id_q;
    byte_count_d = byte_count_q;
    seq_d        = seq_q;
    sent_count_d = sent_count_q;
    busy_d       = busy_q;
    msg_sent_d   = 1'b0;
    load_d       = 1'b0;
    msg_byte_d   = msg_byte_q;
    data_addr_d  = data_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          msg_id_d     = MessageID;
          byte_count_d = ByteCount;
`ifdef MSG_AUTO_SEQ_EN
          seq_d        = seq_q;
`else
          seq_d        = SequenceNumber;
`endif
          sent_count_d = 16'd0;
          data_addr_d  = '0;
          busy_d       = 1'b1;
          state_d      = ST_HEADER_WAIT;
        end
      end
      ST_HEADER_WAIT: begin
        if (SerialReady) begin
          msg_byte_d   = hdr_byte;
          load_d       = 1'b1;
          sent_count_d = sent_count_q + 16'd1;
          state_d      = ST_HEADER_HOLD;
        end
      end
      // Holdoff cycles give the serializer time to drop SerialReady after a load.
      ST_HEADER_HOLD: begin
        if (sent_count_q < HDR_LEN)      state_d = ST_HEADER_WAIT;
        else if (eff_len == HDR_LEN)     state_d = ST_MSG_DONE;
        else                             state_d = ST_DATA_READ;
      end
      ST_DATA_READ: state_d = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (SerialReady) begin
          msg_byte_d   = DataByte;
          load_d       = 1'b1;
          sent_count_d = sent_count_q + 16'd1;
          data_addr_d  = data_addr_q + 1'b1;
          state_d      = ST_DATA_HOLD;
        end
      end
      ST_DATA_HOLD: state_d = (sent_count_q == eff_len) ? ST_MSG_DONE : ST_DATA_READ;
      ST_MSG_DONE: begin
        msg_sent_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
`ifdef MSG_AUTO_SEQ_EN
        seq_d      = seq_q + 16'd1;
`else
        seq_d      = seq_q;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q      <= ST_IDLE;
      msg_id_q     <= 16'd0;
      byte_count_q <= 16'd0;
      seq_q        <= 16'd0;
      sent_count_q <= 16'd0;
      busy_q       <= 1'b0;
      msg_sent_q   <= 1'b0;
      load_q       <= 1'b0;
      msg_byte_q   <= 8'd0;
      data_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      msg_id_q     <= msg_id_d;
      byte_count_q <= byte_count_d;
      seq_q        <= seq_d;
      sent_count_q <= sent_count_d;
      busy_q       <= busy_d;
      msg_sent_q   <= msg_sent_d;
      load_q       <= load_d;
      msg_byte_q   <= msg_byte_d;
      data_addr_q  <= data_addr_d;
    end
  end

  assign Busy        = busy_q;
  assign MessageSent = msg_sent_q;
  assign LoadByte    = load_q;
  assign MessageByte = msg_byte_q;
  assign DataAddr    = data_addr_q;

endmodule

// File: tb/tb_msg_header_mux.sv
// Randomized and directed bench for msg_header_mux against a byte-queue reference model.
module tb_msg_header_mux;

  logic        Clock;
  logic        Clear;
  logic        Start;
  logic [15:0] MessageID;
  logic [15:0] SequenceNumber;
  logic [15:0] ByteCount;
  logic        Busy;
  logic        MessageSent;
  logic [7:0]  MessageByte;
  logic        LoadByte;
  logic        SerialReady;
  logic [7:0]  DataAddr;
  logic [7:0]  DataByte;

  msg_header_mux #(.DATA_ADDR_WIDTH(8)) dut (
    .Clock          (Clock),
    .Clear          (Clear),
    .Start          (Start),
    .MessageID      (MessageID),
    .SequenceNumber (SequenceNumber),
    .ByteCount      (ByteCount),
    .Busy           (Busy),
    .MessageSent    (MessageSent),
    .MessageByte    (MessageByte),
    .LoadByte       (LoadByte),
    .SerialReady    (SerialReady),
    .DataAddr       (DataAddr),
    .DataByte       (DataByte)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  logic        rdy_at_edge = 1'b0;
  bit          rdy_random = 1'b0;
  bit          force_low  = 1'b0;
  logic [7:0]  ram [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_addr_end = 8'd0;
  logic [15:0] exp_seq_ctr = 16'd0;
  int          msg_loads = 0;
  int          nloaded = 0;
  int          sent_pulses = 0;
  int          pulses_before = 0;
  int          start_cyc = 0;
  int          first_load_cyc = 0;
  int          last_load_cyc = 0;
  int          done_cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Payload RAM with one cycle of read latency.
  always @(posedge Clock) DataByte <= ram[DataAddr];

  always @(posedge Clock) begin
    cyc++;
    rdy_at_edge = SerialReady;
    #1;
    SerialReady = force_low ? 1'b0 : (rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  always @(negedge Clock) begin
    if (LoadByte) begin
      check("ready_at_load", 32'(rdy_at_edge), 32'd1);
      if (msg_loads > 0)
        check("load_spacing", 32'((cyc - last_load_cyc) >= (msg_loads >= 8 ? 3 : 2)), 32'd1);
      else
        first_load_cyc = cyc;
      last_load_cyc = cyc;
      check("load_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("msg_byte", 32'(MessageByte), 32'(exp_q.pop_front()));
      msg_loads++;
      nloaded++;
    end
    if (MessageSent) begin
      sent_pulses++;
      done_cyc = cyc;
      exp_seq_ctr = exp_seq_ctr + 16'd1;
    end
  end

  // Reference: header fields little-endian, then (L-8) RAM bytes from address 0 upward.
  task automatic push_expected(input logic [15:0] id, input logic [15:0] seq, input logic [15:0] bc);
    logic [15:0] s;
    int          len;
`ifdef MSG_AUTO_SEQ_EN
    s = exp_seq_ctr;
`else
    s = seq;
`endif
    len = (int'(bc) < 8) ? 8 : int'(bc);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    exp_q.push_back(bc[7:0]);
    exp_q.push_back(bc[15:8]);
    exp_q.push_back(id[7:0]);
    exp_q.push_back(id[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
    for (int i = 0; i < len - 8; i++) exp_q.push_back(ram[i % 256]);
    exp_addr_end = 8'((len - 8) % 256);
  endtask

  task automatic send_start(input logic [15:0] id, input logic [15:0] seq, input logic [15:0] bc);
    @(posedge Clock); #2;
    MessageID = id; SequenceNumber = seq; ByteCount = bc; Start = 1'b1;
    push_expected(id, seq, bc);
    msg_loads = 0;
    pulses_before = sent_pulses;
    @(posedge Clock); #2;
    Start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(Busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sent_pulses == pulses_before; i++) begin
      @(negedge Clock); #1;
    end
    check("done_in_budget", 32'(sent_pulses - pulses_before), 32'd1);
    check("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    check("data_addr_end", 32'(DataAddr), 32'(exp_addr_end));
    @(negedge Clock); #1;
    check("sent_single_pulse", 32'(MessageSent), 32'd0);
    check("busy_after_done", 32'(Busy), 32'd0);
  endtask

  task automatic wait_loads(input int n);
    for (int i = 0; i < 500 && msg_loads < n; i++) begin
      @(negedge Clock); #1;
    end
    check("reach_loads", 32'(msg_loads >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_sent"}, 32'(MessageSent), 32'd0);
    check({tag, "_load"}, 32'(LoadByte), 32'd0);
    check({tag, "_byte"}, 32'(MessageByte), 32'd0);
    check({tag, "_addr"}, 32'(DataAddr), 32'd0);
  endtask

  task automatic apply_clear();
    Clear = 1'b0;
    exp_q.delete();
    exp_seq_ctr = 16'd0;
    repeat (3) @(posedge Clock);
    #2 Clear = 1'b1;
  endtask

  initial begin
    int nl;
    logic [15:0] bc;
    Clear = 1'b0; Start = 1'b0; MessageID = 16'd0; SequenceNumber = 16'd0;
    ByteCount = 16'd0; SerialReady = 1'b1; DataByte = 8'd0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    repeat (3) @(posedge Clock);
    #2;
    check_reset_outputs("reset");
    Clear = 1'b1;

    // Header-only with latency checks.
    send_start(16'h0102, 16'h0003, 16'd8);
    wait_done(100);
    check("first_load_latency", 32'(first_load_cyc - start_cyc), 32'd1);
    check("header_only_done_latency", 32'(done_cyc - start_cyc), 32'd17);

    // Short payload.
    ram[0] = 8'hAA; ram[1] = 8'hBB; ram[2] = 8'hCC;
    send_start(16'h5A5A, 16'h0010, 16'd11);
    wait_done(200);
    check("payload_addr_is_3", 32'(DataAddr), 32'd3);

    // Backpressure before byte 5.
    send_start(16'hBEEF, 16'h0042, 16'd10);
    wait_loads(5);
    force_low = 1'b1;
    nl = nloaded;
    repeat (20) @(negedge Clock);
    check("stall_no_load", 32'(nloaded - nl), 32'd0);
    check("stall_busy", 32'(Busy), 32'd1);
    check("stall_holds_byte", 32'(MessageByte), 32'h00EF);
    force_low = 1'b0;
    wait_done(200);

    // Start while busy is dropped; ByteCount below header size sent as header-only.
    send_start(16'h0A0B, 16'h0C0D, 16'd3);
    wait_loads(3);
    MessageID = 16'hFFFF; ByteCount = 16'd20; Start = 1'b1;
    @(posedge Clock); #2 Start = 1'b0;
    wait_done(100);
    nl = sent_pulses;
    repeat (30) @(negedge Clock);
    check("no_queued_start", 32'(sent_pulses), 32'(nl));
    check("idle_after_ignored", 32'(Busy), 32'd0);

    // Clear during payload byte 2 aborts asynchronously.
    send_start(16'h1357, 16'h2468, 16'd14);
    wait_loads(11);
    Clear = 1'b0;
    exp_q.delete();
    exp_seq_ctr = 16'd0;
    #1;
    check_reset_outputs("async_clear");
    repeat (2) @(posedge Clock);
    #2 Clear = 1'b1;
    nl = nloaded;
    repeat (20) @(negedge Clock);
    check("no_resume_loads", 32'(nloaded - nl), 32'd0);
    check("no_resume_busy", 32'(Busy), 32'd0);
    send_start(16'h7777, 16'h8888, 16'd12);
    wait_done(200);

    // Payload longer than RAM depth wraps the address.
    send_start(16'h0001, 16'h0002, 16'd270);
    wait_done(1500);

    // Randomized messages under random backpressure.
    rdy_random = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bc = 16'($urandom_range(0, 24));
      send_start(16'($urandom), 16'($urandom), bc);
      wait_done(2000);
    end
    rdy_random = 1'b0;

    // Three header-only messages from a fresh reset.
    apply_clear();
    for (int k = 0; k < 3; k++) begin
      send_start(16'h00A0 + 16'(k), 16'(k), 16'd8);
      wait_done(100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/msg_header_mux.md
# msg_header_mux

Transmit-side counterpart of the message receiver in the Arduino messaging path. On a Start pulse it builds the 8-byte message header (sync word 0x1234, byte count, message ID, sequence number, each 16-bit little-endian), then streams the payload bytes from a data RAM. Every byte is handed to the parallel-to-serial transmitter through a one-byte load handshake. It sits between the message controller and the serializer that drives the Arduino link.

## Interface
- DATA_ADDR_WIDTH, 8, width of the payload RAM byte address.
- Clock  input  1  system clock; all logic on posedge.
- Clear  input  1  reset, asynchronous, active-low.
- Start  input  1  one-cycle request to send a message; honoured only in Idle.
- MessageID  input  16  latched on an accepted Start.
- SequenceNumber  input  16  latched on an accepted Start. Unused when MSG_AUTO_SEQ_EN is defined.
- ByteCount  input  16  total message length including the 8 header bytes; latched on an accepted Start.
- Busy  output  1  high from the cycle after an accepted Start through the MsgDone state.
- MessageSent  output  1  one-cycle pulse in MsgDone.
- MessageByte  output  8  byte to serializer; registered, holds its value between loads.
- LoadByte  output  1  one-cycle pulse; MessageByte is valid in the same cycle.
- SerialReady  input  1  serializer is idle and can accept a byte.
- DataAddr  output  DATA_ADDR_WIDTH  payload RAM read address, registered.
- DataByte  input  8  payload RAM read data; valid 1 cycle after DataAddr.

## Operation
- Header byte order, index 0..7: 0x34, 0x12, ByteCount[7:0], ByteCount[15:8], MessageID[7:0], MessageID[15:8], Seq[7:0], Seq[15:8].
- The transmitted byte-count field carries the latched ByteCount value unchanged.
- Effective length L = max(ByteCount, 8). Payload length is L−8.
- A 16-bit counter SentCount counts bytes transmitted. It resets to 0 on Start.
- States:
  - Idle: on Start, latch the inputs, clear SentCount and DataAddr, go to HeaderWait.
  - HeaderWait: when SerialReady=1, drive header byte [SentCount], pulse LoadByte, increment SentCount, go to HeaderHold.
  - HeaderHold: one-cycle holdoff. If SentCount<8, go to HeaderWait. Else if L==8, go to MsgDone. Else go to DataRead.
  - DataRead: DataAddr is already valid; wait one cycle for RAM latency, go to DataWait.
  - DataWait: when SerialReady=1, MessageByte←DataByte, pulse LoadByte, increment SentCount and DataAddr, go to DataHold.
  - DataHold: one-cycle holdoff. If SentCount==L, go to MsgDone. Else go to DataRead.
  - MsgDone: pulse MessageSent, go to Idle.
- The holdoff states exist because SerialReady is not re-sampled in the cycle after LoadByte. The serializer must drop SerialReady within that cycle.
- DataAddr wraps modulo 2^DATA_ADDR_WIDTH when the payload exceeds RAM depth. There is no error flag.
- Start outside Idle is ignored and is not queued.
- Illegal state encodings go to Idle.

## Timing
- Reset values: Busy=0, MessageSent=0, LoadByte=0, MessageByte=0x00, DataAddr=0, state Idle, latched fields 0.
- If Start is at cycle N and SerialReady is held high, LoadByte for byte 0 fires at N+1.
- Header bytes are sent at most one per 2 cycles.
- Payload bytes are sent at most one per 3 cycles.
- A header-only message with SerialReady held high: MessageSent fires at N+17.
- A Clear assertion mid-message aborts it immediately. Nothing resumes after release.
- SerialReady low stalls the block in HeaderWait or DataWait indefinitely, with outputs held.

## Configuration
- MSG_AUTO_SEQ_EN defined:
  - The SequenceNumber input is ignored.
  - An internal 16-bit counter, reset to 0, supplies the sequence field.
  - The counter increments in MsgDone and wraps 0xFFFF→0x0000.
- MSG_AUTO_SEQ_EN undefined: the sequence field is the latched SequenceNumber input.

## Structure
- Shared package msg_defs_pkg holds:
  - SYNC_BYTE_LO=8'h34, SYNC_BYTE_HI=8'h12, HEADER_BYTE_COUNT=8.
  - The header byte-index constants.
  - The state enum typedef, which the receiver also uses for its own states.
- One natural sub-module: msg_header_rom. It is a combinational 8:1 byte select of the latched header fields by SentCount[2:0].

## Test plan
- Header-only: ID=0x0102, Seq=0x0003, ByteCount=8 → LoadByte sequence 34 12 08 00 02 01 03 00, then one MessageSent pulse.
- Payload: ByteCount=11, RAM[0..2]=AA BB CC → header, then AA BB CC. DataAddr ends at 3.
- Backpressure: SerialReady held low 20 cycles before byte 5 → no LoadByte during the stall, and the byte order is unchanged.
- Start pulsed while Busy, and ByteCount=3 → the second Start is ignored; ByteCount=3 is sent as header-only with field bytes 03 00.
- Clear low during payload byte 2 → all outputs return to reset values asynchronously. A new Start afterwards sends a correct message.
- MSG_AUTO_SEQ_EN: three header-only messages → sequence fields 0000, 0100, 0200 in byte order (lo,hi).
